// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types and constants for the sha256 round scheduler
//
// Contents:
//   word_t         32-bit sha256 word
//   ROUND_IDX_W    width of the round index t
//   sched_state_e  scheduler FSM states
//   SHA256_IV      standard initial hash value H(0), a=[0]..h=[7]
package sha256_pkg;

   typedef logic [31:0] word_t;

   localparam int ROUND_IDX_W = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_FINAL,
      ST_DONE
   } sched_state_e;

   localparam word_t SHA256_IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

endpackage

// File: rtl/sha256_w_window.sv
// rtl/sha256_w_window.sv - 16-word message schedule history and round W tap mux
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_load       load history from i_msg (block accept)
//   i_msg[16]    message words M[0..15]
//   i_shift      shift history down by one, i_w enters at [15]
//   i_w          new schedule word W[t] from the round core
//   i_t          current round index
//   o_w[4]       W window for the round core
module sha256_w_window
   import sha256_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_load,
   input  word_t                  i_msg [16],
   input  logic                   i_shift,
   input  word_t                  i_w,
   input  logic [ROUND_IDX_W-1:0] i_t,
   output word_t                  o_w [4]
);

   word_t hist_q [16];
   word_t hist_d [16];

   always_comb begin
      hist_d = hist_q;
      if (i_load) begin
         hist_d = i_msg;
      end else if (i_shift) begin
         for (int i = 0; i < 15; i++) begin
            hist_d[i] = hist_q[i+1];
         end
         hist_d[15] = i_w;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '{default: '0};
      end else begin
         hist_q <= hist_d;
      end
   end

   // For t<16 the history still holds M[0..15] unshifted, so M[t] is
   // indexed directly and the sigma inputs are zeroed; the core then
   // returns W[t]=M[t]. From t=16 on, hist[0] is always W[t-16].
   always_comb begin
      o_w = '{default: '0};
      if (i_t < ROUND_IDX_W'(16)) begin
         o_w[0] = hist_q[i_t[3:0]];
      end else begin
         o_w[0] = hist_q[0];
         o_w[1] = hist_q[1];
         o_w[2] = hist_q[9];
         o_w[3] = hist_q[14];
      end
   end

endmodule

// File: rtl/sha256_round_sched.sv
// rtl/sha256_round_sched.sv - sequences the sha256 round core through one block compression
//
// Optional feature macro: SHA256_SCHED_FINAL_ADD_EN
//   defined   : o_hout[i] = hin[i] + letters[i] (feed-forward inside)
//   undefined : o_hout[i] = letters[i] (chaining done externally)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_blk_valid / o_blk_ready  block + chaining value handshake
//   i_msg[16], i_hin[8]        message words, chaining value a..h
//   o_hout[8], o_hout_valid,
//   i_hout_ready               result handshake, held until taken
//   o_busy                     block in flight
//   o_err                      sticky watchdog error
//   o_rnd_*                    issue side to round core
//   i_rnd_*                    return side from round core
module sha256_round_sched
   import sha256_pkg::*;
#(
   parameter int ROUNDS = 64,
   parameter int WDOG   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_blk_valid,
   output logic                   o_blk_ready,
   input  word_t                  i_msg [16],
   input  word_t                  i_hin [8],
   output word_t                  o_hout [8],
   output logic                   o_hout_valid,
   input  logic                   i_hout_ready,
   output logic                   o_busy,
   output logic                   o_err,
   output word_t                  o_rnd_letters [8],
   output logic [ROUND_IDX_W-1:0] o_rnd_counter,
   output word_t                  o_rnd_w [4],
   output logic                   o_rnd_ready,
   input  word_t                  i_rnd_letters [8],
   input  logic                   i_rnd_letters_valid,
   input  word_t                  i_rnd_w,
   input  logic                   i_rnd_w_valid
);

   localparam int WDOG_W = $clog2(WDOG + 1);

   sched_state_e           state_q, state_d;
   logic [ROUND_IDX_W-1:0] t_q, t_d;
   word_t                  letters_q [8];
   word_t                  letters_d [8];
   word_t                  hout_q [8];
   word_t                  hout_d [8];
   logic [WDOG_W-1:0]      wdog_q, wdog_d;
   logic                   err_q, err_d;
   logic                   win_load;
   logic                   win_shift;

`ifdef SHA256_SCHED_FINAL_ADD_EN
   word_t                  hin_q [8];
   word_t                  hin_d [8];
`endif

   sha256_w_window u_w_window (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (win_load),
      .i_msg   (i_msg),
      .i_shift (win_shift),
      .i_w     (i_rnd_w),
      .i_t     (t_q),
      .o_w     (o_rnd_w)
   );

   always_comb begin
      state_d      = state_q;
      t_d          = t_q;
      letters_d    = letters_q;
      hout_d       = hout_q;
      wdog_d       = wdog_q;
      err_d        = err_q;
      win_load     = 1'b0;
      win_shift    = 1'b0;
      o_rnd_ready  = 1'b0;
      o_hout_valid = 1'b0;
`ifdef SHA256_SCHED_FINAL_ADD_EN
      hin_d        = hin_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (i_blk_valid) begin
               win_load  = 1'b1;
               letters_d = i_hin;
`ifdef SHA256_SCHED_FINAL_ADD_EN
               hin_d     = i_hin;
`endif
               t_d       = '0;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            o_rnd_ready = 1'b1;
            wdog_d      = '0;
            state_d     = ST_WAIT;
         end
         ST_WAIT: begin
            // Returned W is only kept once the window has run past M[15].
            if (i_rnd_w_valid && (t_q >= ROUND_IDX_W'(16))) begin
               win_shift = 1'b1;
            end
            if (i_rnd_letters_valid) begin
               letters_d = i_rnd_letters;
               if (t_q == ROUND_IDX_W'(ROUNDS - 1)) begin
                  state_d = ST_FINAL;
               end else begin
                  t_d     = t_q + 1'b1;
                  state_d = ST_ISSUE;
               end
            end else if (wdog_q == WDOG_W'(WDOG)) begin
               // This is WAIT cycle WDOG+1: abandon the block.
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         ST_FINAL: begin
            for (int i = 0; i < 8; i++) begin
`ifdef SHA256_SCHED_FINAL_ADD_EN
               hout_d[i] = hin_q[i] + letters_q[i];
`else
               hout_d[i] = letters_q[i];
`endif
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            o_hout_valid = 1'b1;
            if (i_hout_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         t_q       <= '0;
         letters_q <= '{default: '0};
         hout_q    <= '{default: '0};
         wdog_q    <= '0;
         err_q     <= 1'b0;
`ifdef SHA256_SCHED_FINAL_ADD_EN
         hin_q     <= '{default: '0};
`endif
      end else begin
         state_q   <= state_d;
         t_q       <= t_d;
         letters_q <= letters_d;
         hout_q    <= hout_d;
         wdog_q    <= wdog_d;
         err_q     <= err_d;
`ifdef SHA256_SCHED_FINAL_ADD_EN
         hin_q     <= hin_d;
`endif
      end
   end

   // Ready is gated by rst_n so every output reads 0 while reset is held.
   assign o_blk_ready   = (state_q == ST_IDLE) && rst_n;
   assign o_busy        = (state_q != ST_IDLE);
   assign o_err         = err_q;
   assign o_hout        = hout_q;
   assign o_rnd_letters = letters_q;
   assign o_rnd_counter = t_q;

endmodule
